// File: rtl/dbus_mem_pkg.sv
// Shared definitions for the data-bus memory responder: size encodings,
// timer register offsets, default region bases, read-source select and
// the byte-lane strobe helper.
package dbus_mem_pkg;

   localparam logic [2:0] SIZE_B = 3'b001;
   localparam logic [2:0] SIZE_H = 3'b010;
   localparam logic [2:0] SIZE_W = 3'b100;

   // Timer register byte offsets from TIMER_BASE
   localparam logic [4:0] TMR_MTIME_LO = 5'h00;
   localparam logic [4:0] TMR_MTIME_HI = 5'h04;
   localparam logic [4:0] TMR_CMP_LO   = 5'h08;
   localparam logic [4:0] TMR_CMP_HI   = 5'h0C;
   localparam logic [4:0] TMR_CTRL     = 5'h10;
   localparam logic [31:0] TMR_SPAN    = 32'd20;

   localparam logic [31:0] DEF_RAM_BASE   = 32'h1000_0000;
   localparam logic [31:0] DEF_TIMER_BASE = 32'h0200_0000;

   // Which register drives the read-data bus
   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_RAM,
      SRC_TIMER
   } rd_src_e;

   // Byte-lane strobes for a size/address pair; zero for an illegal size
   function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] s;
      s = 4'h0;
      case (size)
         SIZE_B:  s = 4'b0001 << a;
         SIZE_H:  s = 4'b0011 << {a[1], 1'b0};
         SIZE_W:  s = 4'hF;
         default: s = 4'h0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dbus_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, enable bit and a
// registered interrupt. Only instantiated when DBUS_MEM_TIMER_EN is defined.
module dbus_timer
   import dbus_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  widx,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [63:0] mtime_reg, mtime_next;
   logic [63:0] cmp_reg, cmp_next;
   logic        en_reg, en_next;
   logic        irq_reg;
   logic [4:0]  off;

   assign off = {widx, 2'b00};

   // Next-state: a write to either mtime half replaces the increment for that cycle
   always_comb begin
      mtime_next = en_reg ? mtime_reg + 64'd1 : mtime_reg;
      cmp_next   = cmp_reg;
      en_next    = en_reg;
      if (wr_en) begin
         case (off)
            TMR_MTIME_LO: mtime_next = {mtime_reg[63:32], wdata};
            TMR_MTIME_HI: mtime_next = {wdata, mtime_reg[31:0]};
            TMR_CMP_LO:   cmp_next   = {cmp_reg[63:32], wdata};
            TMR_CMP_HI:   cmp_next   = {wdata, cmp_reg[31:0]};
            TMR_CTRL:     en_next    = wdata[0];
            default:      ;
         endcase
      end
   end

   // Read mux of the current register values
   always_comb begin
      rdata = 32'h0;
      case (off)
         TMR_MTIME_LO: rdata = mtime_reg[31:0];
         TMR_MTIME_HI: rdata = mtime_reg[63:32];
         TMR_CMP_LO:   rdata = cmp_reg[31:0];
         TMR_CMP_HI:   rdata = cmp_reg[63:32];
         TMR_CTRL:     rdata = {31'h0, en_reg};
         default:      rdata = 32'h0;
      endcase
   end

   // Timer state and interrupt, compare done on the post-update values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_reg <= 64'h0;
         cmp_reg   <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_reg    <= 1'b0;
         irq_reg   <= 1'b0;
      end else begin
         mtime_reg <= mtime_next;
         cmp_reg   <= cmp_next;
         en_reg    <= en_next;
         irq_reg   <= en_next && (mtime_next >= cmp_next);
      end
   end

   assign irq = irq_reg;

endmodule

// File: rtl/dbus_mem.sv
// Data-bus responder: decodes dbus requests, writes on-chip RAM with byte
// strobes and returns registered read data one cycle later. Optional
// machine timer enabled by defining DBUS_MEM_TIMER_EN.
module dbus_mem
   import dbus_mem_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
   parameter logic [31:0] TIMER_BASE = DEF_TIMER_BASE
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] dbus_addr_i,
   input  logic        dbus_rd_i,
   input  logic        dbus_we_i,
   input  logic [2:0]  dbus_size_i,
   input  logic [31:0] dbus_data_i,
   output logic [31:0] dbus_data_o,
   output logic        err_o,
   output logic        irq_o
);

`ifdef DBUS_MEM_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
   logic [31:0]           ram_rdata_reg;
   logic [31:0]           tmr_rdata;
   logic [31:0]           tmr_rdata_reg;
   rd_src_e               rd_src_reg;
   logic                  err_reg;

   logic                  active, both, size_ok, align_ok;
   logic                  in_ram, in_timer, reject, ok;
   logic                  ram_we, ram_rd, tmr_rd;
   logic [3:0]            strb;
   logic [31:0]           tmr_off;
   logic [ADDR_WIDTH-1:0] widx;

   // Request decode and rejection rules
   always_comb begin
      active   = dbus_rd_i | dbus_we_i;
      both     = dbus_rd_i & dbus_we_i;
      size_ok  = (dbus_size_i == SIZE_B) || (dbus_size_i == SIZE_H) || (dbus_size_i == SIZE_W);
      align_ok = 1'b1;
      if (dbus_size_i == SIZE_H) align_ok = ~dbus_addr_i[0];
      if (dbus_size_i == SIZE_W) align_ok = (dbus_addr_i[1:0] == 2'b00);
      in_ram   = (dbus_addr_i[31:ADDR_WIDTH+2] == RAM_BASE[31:ADDR_WIDTH+2]);
      tmr_off  = dbus_addr_i - TIMER_BASE;
      in_timer = TIMER_EN && (tmr_off < TMR_SPAN);
      reject   = active && (both || !size_ok || !align_ok || !(in_ram || in_timer) ||
                            (in_timer && dbus_size_i != SIZE_W));
      ok       = active && !reject;
      ram_we   = ok && dbus_we_i && in_ram;
      ram_rd   = ok && dbus_rd_i && in_ram;
      tmr_rd   = ok && dbus_rd_i && in_timer;
      strb     = lane_strobe(dbus_size_i, dbus_addr_i[1:0]);
      widx     = dbus_addr_i[ADDR_WIDTH+1:2];
   end

   // RAM: byte-strobed write and registered read (contents not reset)
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) mem[widx][8*i +: 8] <= dbus_data_i[8*i +: 8];
         end
      end
      if (ram_rd) ram_rdata_reg <= mem[widx];
      if (tmr_rd) tmr_rdata_reg <= tmr_rdata;
   end

   // Read-source select and error pulse; only reads move the select
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_src_reg <= SRC_ZERO;
         err_reg    <= 1'b0;
      end else begin
         err_reg <= reject;
         if (dbus_rd_i) begin
            if (reject)      rd_src_reg <= SRC_ZERO;
            else if (in_ram) rd_src_reg <= SRC_RAM;
            else             rd_src_reg <= SRC_TIMER;
         end
      end
   end

   // Output mux over the held read registers
   always_comb begin
      dbus_data_o = 32'h0;
      case (rd_src_reg)
         SRC_RAM:   dbus_data_o = ram_rdata_reg;
         SRC_TIMER: dbus_data_o = tmr_rdata_reg;
         default:   dbus_data_o = 32'h0;
      endcase
   end

   assign err_o = err_reg;

`ifdef DBUS_MEM_TIMER_EN
   logic tmr_wr;
   assign tmr_wr = ok && dbus_we_i && in_timer;

   dbus_timer u_timer (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .wr_en (tmr_wr),
      .widx  (tmr_off[4:2]),
      .wdata (dbus_data_i),
      .rdata (tmr_rdata),
      .irq   (irq_o)
   );
`else
   assign tmr_rdata = 32'h0;
   assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_mem.sv
// Directed, table-driven bench for dbus_mem. Timer sequences compile in
// only when DBUS_MEM_TIMER_EN is defined.
module tb_dbus_mem;

   localparam logic [31:0] RB = 32'h1000_0000;
   localparam logic [31:0] TB = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic        rd = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  size = 3'b100;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        err;
   logic        irq;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        rd;
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   dbus_mem dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .dbus_addr_i (addr),
      .dbus_rd_i   (rd),
      .dbus_we_i   (we),
      .dbus_size_i (size),
      .dbus_data_i (wdata),
      .dbus_data_o (rdata),
      .err_o       (err),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Present one request for one cycle; returns 1 ns after the capturing edge
   task automatic cyc(input logic r, input logic w, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] d);
      rd = r; we = w; size = s; addr = a; wdata = d;
      @(posedge clk);
      #1;
      $display("txn rd=%b we=%b size=%b addr=%h wdata=%h -> data=%h err=%b irq=%b",
               r, w, s, a, d, rdata, err, irq);
   endtask

   function automatic void add(input logic r, input logic w, input logic [2:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] ed, input logic ee);
      vec_t v;
      v.rd = r; v.we = w; v.size = s; v.addr = a; v.wdata = d;
      v.exp_data = ed; v.exp_err = ee;
      vecs.push_back(v);
   endfunction

   initial begin
      //   rd  we  size    addr          wdata          exp_data       err
      add(0, 1, 3'b100, RB + 32'h10,   32'hDEAD_BEEF, 32'h0000_0000, 0);
      add(1, 0, 3'b100, RB + 32'h10,   32'h0,         32'hDEAD_BEEF, 0);
      add(0, 1, 3'b100, RB + 32'h10,   32'h1122_3344, 32'hDEAD_BEEF, 0);
      add(0, 1, 3'b001, RB + 32'h13,   32'h5A00_0000, 32'hDEAD_BEEF, 0);
      add(1, 0, 3'b100, RB + 32'h10,   32'h0,         32'h5A22_3344, 0);
      add(0, 1, 3'b010, RB + 32'h12,   32'hABCD_0000, 32'h5A22_3344, 0);
      add(1, 0, 3'b100, RB + 32'h10,   32'h0,         32'hABCD_3344, 0);
      add(0, 1, 3'b001, RB + 32'h10,   32'h0000_00EE, 32'hABCD_3344, 0);
      add(1, 0, 3'b001, RB + 32'h10,   32'h0,         32'hABCD_33EE, 0);
      add(1, 0, 3'b100, RB + 32'h02,   32'h0,         32'h0000_0000, 1);
      add(0, 1, 3'b011, RB + 32'h10,   32'hFFFF_FFFF, 32'h0000_0000, 1);
      add(1, 0, 3'b100, RB + 32'h10,   32'h0,         32'hABCD_33EE, 0);
      add(1, 0, 3'b010, RB + 32'h11,   32'h0,         32'h0000_0000, 1);
      add(1, 1, 3'b100, RB + 32'h10,   32'h0,         32'h0000_0000, 1);
      add(1, 0, 3'b100, 32'h2000_0000, 32'h0,         32'h0000_0000, 1);
      add(1, 0, 3'b100, RB - 32'h4,    32'h0,         32'h0000_0000, 1);
      add(1, 0, 3'b000, RB + 32'h10,   32'h0,         32'h0000_0000, 1);
      add(0, 0, 3'b100, RB + 32'h10,   32'h0,         32'h0000_0000, 0);
      add(0, 1, 3'b100, RB + 32'h20,   32'hCAFE_F00D, 32'h0000_0000, 0);
      add(1, 0, 3'b100, RB + 32'h20,   32'h0,         32'hCAFE_F00D, 0);
      add(0, 1, 3'b100, RB + 32'h30,   32'h0101_0101, 32'hCAFE_F00D, 0);
      add(0, 1, 3'b100, RB + 32'h34,   32'h0202_0202, 32'hCAFE_F00D, 0);
      add(0, 1, 3'b100, RB + 32'h38,   32'h0303_0303, 32'hCAFE_F00D, 0);
      add(0, 1, 3'b100, RB + 32'h3C,   32'h0404_0404, 32'hCAFE_F00D, 0);
      add(1, 0, 3'b100, RB + 32'h30,   32'h0,         32'h0101_0101, 0);
      add(1, 0, 3'b100, RB + 32'h34,   32'h0,         32'h0202_0202, 0);
      add(1, 0, 3'b100, RB + 32'h38,   32'h0,         32'h0303_0303, 0);
      add(1, 0, 3'b100, RB + 32'h3C,   32'h0,         32'h0404_0404, 0);
      add(0, 0, 3'b100, RB + 32'h3C,   32'h0,         32'h0404_0404, 0);
      add(0, 0, 3'b100, RB + 32'h3C,   32'h0,         32'h0404_0404, 0);
      add(0, 1, 3'b010, RB + 32'h3E,   32'hBEEF_0000, 32'h0404_0404, 0);
      add(1, 0, 3'b100, RB + 32'h3C,   32'h0,         32'hBEEF_0404, 0);
      add(0, 1, 3'b100, RB + 32'h3FFC, 32'h1234_5678, 32'hBEEF_0404, 0);
      add(1, 0, 3'b100, RB + 32'h3FFC, 32'h0,         32'h1234_5678, 0);
      add(1, 0, 3'b100, RB + 32'h4000, 32'h0,         32'h0000_0000, 1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset data", rdata, 32'h0);
      check("reset err", {31'h0, err}, 32'h0);
      check("reset irq", {31'h0, irq}, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         cyc(vecs[i].rd, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d data", i), rdata, vecs[i].exp_data);
         check($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      end

`ifdef DBUS_MEM_TIMER_EN
      // Timer: irq rises 20 cycles after enable with mtimecmp = 20
      cyc(0, 1, 3'b100, TB + 32'h08, 32'd20);
      cyc(0, 1, 3'b100, TB + 32'h0C, 32'd0);
      cyc(0, 1, 3'b100, TB + 32'h10, 32'd1);
      check("tmr ctrl write err", {31'h0, err}, 32'h0);
      repeat (19) cyc(0, 0, 3'b100, RB, 32'h0);
      check("tmr irq before 20", {31'h0, irq}, 32'h0);
      cyc(0, 0, 3'b100, RB, 32'h0);
      check("tmr irq at 20", {31'h0, irq}, 32'h1);
      cyc(1, 0, 3'b100, TB + 32'h00, 32'h0);
      check("tmr mtime_lo read", rdata, 32'd20);
      cyc(0, 1, 3'b100, TB + 32'h08, 32'd1000);
      check("tmr irq falls", {31'h0, irq}, 32'h0);
      cyc(1, 0, 3'b001, TB + 32'h00, 32'h0);
      check("tmr byte err", {31'h0, err}, 32'h1);
      cyc(1, 0, 3'b100, TB + 32'h14, 32'h0);
      check("tmr past end err", {31'h0, err}, 32'h1);
      cyc(0, 1, 3'b100, TB + 32'h08, 32'd0);
      check("tmr irq cmp0", {31'h0, irq}, 32'h1);
`else
      cyc(1, 0, 3'b100, TB, 32'h0);
      check("tmr unmapped err", {31'h0, err}, 32'h1);
      check("tmr unmapped data", rdata, 32'h0);
      check("tmr irq tied", {31'h0, irq}, 32'h0);
`endif

      // Asynchronous reset in the middle of back-to-back reads
      cyc(1, 0, 3'b100, RB + 32'h30, 32'h0);
      check("pre-rst data", rdata, 32'h0101_0101);
      cyc(0, 1, 3'b011, RB + 32'h30, 32'h0);
      check("pre-rst err", {31'h0, err}, 32'h1);
      rd = 1'b1; we = 1'b0; size = 3'b100; addr = RB + 32'h34;
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst data", rdata, 32'h0);
      check("async rst err", {31'h0, err}, 32'h0);
      check("async rst irq", {31'h0, irq}, 32'h0);
      rd = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 0, 3'b100, RB, 32'h0);
      check("post-rst data", rdata, 32'h0);
      check("post-rst err", {31'h0, err}, 32'h0);

`ifdef DBUS_MEM_TIMER_EN
      cyc(1, 0, 3'b100, TB + 32'h10, 32'h0);
      check("post-rst ctrl", rdata, 32'h0);
      cyc(1, 0, 3'b100, TB + 32'h00, 32'h0);
      check("post-rst mtime_lo", rdata, 32'h0);
      cyc(1, 0, 3'b100, TB + 32'h0C, 32'h0);
      check("post-rst cmp_hi", rdata, 32'hFFFF_FFFF);
      check("post-rst irq", {31'h0, irq}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
